box_plotter: RTL and testbench

BOX_PLOTTER -- requirements
Module: box_plotter

---
 rtl/box_plotter_pkg.sv | 18 +
 rtl/vga_address_translator.sv | 20 ++
 rtl/box_plotter.sv | 152 +++++++++++++++
 tb/tb_box_plotter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/box_plotter_pkg.sv
// Shared frame-buffer package: screen geometry, bus widths and the plotter FSM encoding.
package box_plotter_pkg;

   localparam int XSZ    = 8;
   localparam int YSZ    = 7;
   localparam int ADDRSZ = 15;
   localparam int COLSZ  = 3;
   localparam int X_RES  = 160;
   localparam int Y_RES  = 120;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      PLOT = 2'd2,
      DONE = 2'd3
   } stateType;

endpackage

// File: rtl/vga_address_translator.sv
// Maps an (x, y) pixel coordinate to a linear address for a 160-pixel-wide frame buffer.
module vga_address_translator #(
   parameter int XSZ    = box_plotter_pkg::XSZ,
   parameter int YSZ    = box_plotter_pkg::YSZ,
   parameter int ADDRSZ = box_plotter_pkg::ADDRSZ
) (
   input  logic [XSZ-1:0]    x,
   input  logic [YSZ-1:0]    y,
   output logic [ADDRSZ-1:0] memAddress
);

   logic [ADDRSZ-1:0] xWide;
   logic [ADDRSZ-1:0] yWide;

   // Widen before shifting so y*160 cannot lose its upper bits.
   assign xWide      = ADDRSZ'(x);
   assign yWide      = ADDRSZ'(y);
   assign memAddress = (yWide << 7) + (yWide << 5) + xWide;

endmodule

// File: rtl/box_plotter.sv
// Draws a filled or outlined rectangle into the frame buffer, one pixel per cycle in raster order.
module box_plotter #(
   parameter int XSZ    = box_plotter_pkg::XSZ,
   parameter int YSZ    = box_plotter_pkg::YSZ,
   parameter int ADDRSZ = box_plotter_pkg::ADDRSZ,
   parameter int COLSZ  = box_plotter_pkg::COLSZ,
   parameter int X_RES  = box_plotter_pkg::X_RES,
   parameter int Y_RES  = box_plotter_pkg::Y_RES
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              go,
   input  logic              mode,
   input  logic [COLSZ-1:0]  colour,
   input  logic [XSZ-1:0]    box_left,
   input  logic [XSZ-1:0]    box_right,
   input  logic [YSZ-1:0]    box_top,
   input  logic [YSZ-1:0]    box_bottom,
   output logic [ADDRSZ-1:0] wr_addr,
   output logic [COLSZ-1:0]  wr_data,
   output logic              wren,
   output logic              busy,
   output logic              done
);
   import box_plotter_pkg::*;

   localparam logic [XSZ-1:0] X_MAX = XSZ'(X_RES - 1);
   localparam logic [YSZ-1:0] Y_MAX = YSZ'(Y_RES - 1);

   stateType          state;
   stateType          nextState;

   logic              modeQ;
   logic [COLSZ-1:0]  colourQ;
   logic [XSZ-1:0]    leftQ;
   logic [XSZ-1:0]    rightQ;
   logic [YSZ-1:0]    topQ;
   logic [YSZ-1:0]    bottomQ;
   logic [XSZ-1:0]    xCnt;
   logic [YSZ-1:0]    yCnt;

   logic [XSZ-1:0]    clampRight;
   logic [YSZ-1:0]    clampBottom;
   logic              boxValid;
   logic              lastCol;
   logic              lastRow;
   logic              onBorder;
   logic [ADDRSZ-1:0] pixelAddr;
   logic [ADDRSZ-1:0] lastAddr;
   logic [COLSZ-1:0]  lastData;

   assign clampRight  = (rightQ > X_MAX) ? X_MAX : rightQ;
   assign clampBottom = (bottomQ > Y_MAX) ? Y_MAX : bottomQ;
   assign boxValid    = (leftQ <= clampRight) && (topQ <= clampBottom);

   assign lastCol  = (xCnt == rightQ);
   assign lastRow  = (yCnt == bottomQ);
   assign onBorder = (xCnt == leftQ) || lastCol || (yCnt == topQ) || lastRow;

   vga_address_translator #(
      .XSZ    (XSZ),
      .YSZ    (YSZ),
      .ADDRSZ (ADDRSZ)
   ) addrTrans (
      .x          (xCnt),
      .y          (yCnt),
      .memAddress (pixelAddr)
   );

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!resetn) state <= IDLE;
      else         state <= nextState;
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      nextState = state;
      wren      = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (go) nextState = LOAD;
         end
         LOAD: nextState = boxValid ? PLOT : DONE;
         PLOT: begin
            wren = modeQ || onBorder;
            if (lastCol && lastRow) nextState = DONE;
         end
         DONE: begin
            done      = 1'b1;
            nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         modeQ    <= 1'b0;
         colourQ  <= '0;
         leftQ    <= '0;
         rightQ   <= '0;
         topQ     <= '0;
         bottomQ  <= '0;
         xCnt     <= '0;
         yCnt     <= '0;
         lastAddr <= '0;
         lastData <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (go) begin
                  modeQ   <= mode;
                  colourQ <= colour;
                  leftQ   <= box_left;
                  rightQ  <= box_right;
                  topQ    <= box_top;
                  bottomQ <= box_bottom;
               end
            end
            LOAD: begin
               // Clamped bounds are stored back so the scan terminates on-screen.
               rightQ  <= clampRight;
               bottomQ <= clampBottom;
               xCnt    <= leftQ;
               yCnt    <= topQ;
            end
            PLOT: begin
               if (lastCol) begin
                  xCnt <= leftQ;
                  yCnt <= yCnt + 1'b1;
               end else begin
                  xCnt <= xCnt + 1'b1;
               end
            end
            default: ;
         endcase
         if (wren) begin
            lastAddr <= pixelAddr;
            lastData <= colourQ;
         end
      end
   end

   // Outputs follow the scan while writing and otherwise hold the last written pixel.
   assign wr_addr = wren ? pixelAddr : lastAddr;
   assign wr_data = wren ? colourQ : lastData;

endmodule

// File: tb/tb_box_plotter.sv
// Self-checking bench for box_plotter: cycle-exact raster model plus directed and random boxes.
module tb_box_plotter;

   localparam int X_RES = 160;
   localparam int Y_RES = 120;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        go = 1'b0;
   logic        mode = 1'b0;
   logic [2:0]  colour = '0;
   logic [7:0]  box_left = '0;
   logic [7:0]  box_right = '0;
   logic [6:0]  box_top = '0;
   logic [6:0]  box_bottom = '0;
   logic [14:0] wr_addr;
   logic [2:0]  wr_data;
   logic        wren;
   logic        busy;
   logic        done;

   int nTests = 0;
   int nFailed = 0;
   int obsAddr[$];
   int obsData[$];
   int cleanAddr[$];
   int plotCycles;
   int lastAddr = 0;
   int lastData = 0;

   box_plotter dut (
      .clk        (clk),
      .resetn     (resetn),
      .go         (go),
      .mode       (mode),
      .colour     (colour),
      .box_left   (box_left),
      .box_right  (box_right),
      .box_top    (box_top),
      .box_bottom (box_bottom),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .wren       (wren),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nTests++;
      if (obs !== exp) begin
         nFailed++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic scramble();
      mode       = ~mode;
      colour     = ~colour;
      box_left   = 8'($urandom);
      box_right  = 8'($urandom);
      box_top    = 7'($urandom);
      box_bottom = 7'($urandom);
   endtask

   // Called at a negedge in IDLE; returns at the negedge of the IDLE cycle after DONE.
   task automatic runBox(input bit m, input int c, input int l, input int r,
                         input int t, input int b, input bit disturb);
      int  cr;
      int  cb;
      bit  valid;
      bit  expWr;
      obsAddr.delete();
      obsData.delete();
      plotCycles = 0;
      cr    = (r > X_RES - 1) ? X_RES - 1 : r;
      cb    = (b > Y_RES - 1) ? Y_RES - 1 : b;
      valid = (l <= cr) && (t <= cb);

      mode       = m;
      colour     = c[2:0];
      box_left   = l[7:0];
      box_right  = r[7:0];
      box_top    = t[6:0];
      box_bottom = b[6:0];
      go         = 1'b1;
      @(negedge clk);
      go = 1'b0;
      checkVal("load_busy", busy, 1);
      checkVal("load_wren", wren, 0);
      checkVal("load_done", done, 0);
      if (disturb) scramble();
      @(negedge clk);

      if (valid) begin
         for (int y = t; y <= cb; y++) begin
            for (int x = l; x <= cr; x++) begin
               expWr = m || (x == l) || (x == cr) || (y == t) || (y == cb);
               plotCycles++;
               checkVal("plot_wren", wren, expWr);
               checkVal("plot_busy", busy, 1);
               checkVal("plot_done", done, 0);
               if (expWr) begin
                  lastAddr = y * X_RES + x;
                  lastData = c;
               end
               checkVal("plot_addr", wr_addr, lastAddr);
               checkVal("plot_data", wr_data, lastData);
               if (wren) begin
                  obsAddr.push_back(int'(wr_addr));
                  obsData.push_back(int'(wr_data));
               end
               if (disturb && plotCycles == 2) begin
                  go = 1'b1;
                  scramble();
               end else begin
                  go = 1'b0;
               end
               @(negedge clk);
            end
         end
      end

      go = 1'b0;
      checkVal("done_pulse", done, 1);
      checkVal("done_wren", wren, 0);
      checkVal("done_busy", busy, 1);
      checkVal("hold_addr", wr_addr, lastAddr);
      @(negedge clk);
      checkVal("idle_busy", busy, 0);
      checkVal("idle_done", done, 0);
   endtask

   initial begin
      int hits;
      int k;
      int gap;

      // Reset state
      repeat (2) @(negedge clk);
      checkVal("rst_wren", wren, 0);
      checkVal("rst_busy", busy, 0);
      checkVal("rst_done", done, 0);
      checkVal("rst_addr", wr_addr, 0);
      checkVal("rst_data", wr_data, 0);
      resetn = 1'b1;
      @(negedge clk);

      // Small fill: four writes, first two cycles after go
      runBox(1'b1, 5, 10, 11, 20, 21, 1'b0);
      checkVal("fill_n", obsAddr.size(), 4);
      if (obsAddr.size() == 4) begin
         checkVal("fill_a0", obsAddr[0], 3210);
         checkVal("fill_a1", obsAddr[1], 3211);
         checkVal("fill_a2", obsAddr[2], 3370);
         checkVal("fill_a3", obsAddr[3], 3371);
         checkVal("fill_d3", obsData[3], 5);
      end

      // Outline 4x3: interior pixels skipped
      runBox(1'b0, 3, 0, 3, 0, 2, 1'b0);
      checkVal("outline_cycles", plotCycles, 12);
      checkVal("outline_n", obsAddr.size(), 10);
      hits = 0;
      foreach (obsAddr[i]) if (obsAddr[i] == 161 || obsAddr[i] == 162) hits++;
      checkVal("outline_skip", hits, 0);

      // Corner pixel, direct and via clamping
      runBox(1'b1, 7, 159, 159, 119, 119, 1'b0);
      checkVal("corner_n", obsAddr.size(), 1);
      if (obsAddr.size() == 1) checkVal("corner_a", obsAddr[0], 19199);
      runBox(1'b0, 6, 159, 200, 119, 127, 1'b0);
      checkVal("clamp_n", obsAddr.size(), 1);
      if (obsAddr.size() == 1) checkVal("clamp_a", obsAddr[0], 19199);

      // Inverted box
      runBox(1'b1, 1, 50, 40, 0, 0, 1'b0);
      checkVal("invert_n", obsAddr.size(), 0);

      // Degenerate outline row writes every pixel
      runBox(1'b0, 4, 20, 27, 30, 30, 1'b0);
      checkVal("degen_n", obsAddr.size(), 8);

      // Mid-operation go and bound changes leave the sequence untouched
      runBox(1'b0, 2, 5, 9, 5, 8, 1'b0);
      cleanAddr = obsAddr;
      runBox(1'b0, 2, 5, 9, 5, 8, 1'b1);
      checkVal("disturb_n", obsAddr.size(), cleanAddr.size());
      hits = 0;
      foreach (obsAddr[i]) if (i < cleanAddr.size() && obsAddr[i] != cleanAddr[i]) hits++;
      checkVal("disturb_seq", hits, 0);
      @(negedge clk);
      checkVal("disturb_idle", busy, 0);

      // go held high restarts right after DONE
      mode = 1'b1; colour = 3'd2;
      box_left = 8'd1; box_right = 8'd1; box_top = 7'd1; box_bottom = 7'd1;
      go = 1'b1;
      k = 0;
      while (!done && k < 20) begin @(negedge clk); k++; end
      checkVal("held_first_done", done, 1);
      @(negedge clk);
      gap = 1;
      while (!done && gap < 20) begin @(negedge clk); gap++; end
      checkVal("held_restart_gap", gap, 4);
      go = 1'b0;
      lastAddr = 161;
      lastData = 2;
      repeat (2) @(negedge clk);
      checkVal("held_idle", busy, 0);

      // Reset during the third write of a 4x4 fill
      mode = 1'b1; colour = 3'd6;
      box_left = 8'd30; box_right = 8'd33; box_top = 7'd40; box_bottom = 7'd43;
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      repeat (3) @(negedge clk);
      checkVal("abort_wren_before", wren, 1);
      resetn = 1'b0;
      @(negedge clk);
      checkVal("abort_wren", wren, 0);
      checkVal("abort_busy", busy, 0);
      checkVal("abort_done", done, 0);
      checkVal("abort_addr", wr_addr, 0);
      lastAddr = 0;
      lastData = 0;
      resetn = 1'b1;
      @(negedge clk);
      runBox(1'b1, 6, 30, 33, 40, 43, 1'b0);
      checkVal("after_abort_n", obsAddr.size(), 16);

      // Random boxes, some near or beyond the screen edges
      for (int i = 0; i < 25; i++) begin
         int l;
         int r;
         int t;
         int b;
         l = int'($urandom_range(0, 170));
         r = l + int'($urandom_range(0, 9)) - 2;
         if (r < 0) r = 0;
         if (r > 255) r = 255;
         t = int'($urandom_range(0, 127));
         b = t + int'($urandom_range(0, 7)) - 2;
         if (b < 0) b = 0;
         if (b > 127) b = 127;
         runBox(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), l, r, t, b,
                $urandom_range(0, 3) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", nTests, nFailed);
      $finish;
   end

endmodule
